parity_serial_rx: RTL and testbench

- Serial frame receiver that deserializes one start bit, WIDTH data bits (LSB first), one parity bit and one stop bit.
- Sits downstream of the word-parity generator and its serializer. It reassembles the word, recomputes the XOR-reduction parity and compares it against the received parity bit.
- Flags parity and framing errors per frame and keeps a saturating error counter for the testbench and status logic.

---
 rtl/parity_rx_pkg.sv | 9 +
 rtl/parity_serial_rx.sv | 118 +++++++++++
 tb/tb_parity_serial_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/parity_rx_pkg.sv
// Shared types and line levels for the parity serial receiver.
package parity_rx_pkg;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/parity_serial_rx.sv
// Start/data/parity/stop frame receiver with parity and framing checks
// and a saturating count of bad frames.
module parity_serial_rx
    import parity_rx_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter bit PARITY_ODD  = 1'b0,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   bit_en,
    input  logic                   serial_in,
    output logic [WIDTH-1:0]       data_out,
    output logic                   data_valid,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] error_count
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    rx_state_t              state_q, state_d;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic                   par_q, par_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   p_err_q, p_err_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic [COUNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            par_q     <= 1'b0;
            cnt_q     <= '0;
            p_err_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            cnt_q     <= cnt_d;
            p_err_q   <= p_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Nothing moves except on a bit strobe; the valid pulse self-clears.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        cnt_d     = cnt_q;
        p_err_d   = p_err_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        err_cnt_d = err_cnt_q;
        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (serial_in == START_LEVEL) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                    end
                end
                DATA: begin
                    shift_d[cnt_q] = serial_in;
                    par_d          = par_q ^ serial_in;
                    cnt_d          = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    p_err_d = par_q ^ serial_in ^ PARITY_ODD;
                    state_d = STOP;
                end
                STOP: begin
                    data_d  = shift_q;
                    perr_d  = p_err_q;
                    ferr_d  = ~serial_in;
                    valid_d = 1'b1;
                    state_d = IDLE;
                    // Counter sticks at all-ones rather than wrapping.
                    if ((p_err_q | ~serial_in) && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + COUNT_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign busy        = (state_q != IDLE);
    assign error_count = err_cnt_q;

endmodule

// File: tb/tb_parity_serial_rx.sv
// Directed scoreboard bench for parity_serial_rx: an 8-bit counter build and
// a 2-bit counter build share one serial line.
module tb_parity_serial_rx;
    import parity_rx_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       bit_en;
    logic       serial_in;
    logic [7:0] data_out,   data_out2;
    logic       data_valid, data_valid2;
    logic       parity_err, parity_err2;
    logic       frame_err,  frame_err2;
    logic       busy,       busy2;
    logic [7:0] error_count;
    logic [1:0] error_count2;

    int compared   = 0;
    int mismatched = 0;

    exp_t       sb[$];
    logic [7:0] model_cnt8 = '0;
    logic [1:0] model_cnt2 = '0;
    logic       prev_valid = 1'b0;

    parity_serial_rx #(.WIDTH(8), .PARITY_ODD(1'b0), .COUNT_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .bit_en(bit_en), .serial_in(serial_in),
        .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy), .error_count(error_count)
    );

    parity_serial_rx #(.WIDTH(8), .PARITY_ODD(1'b0), .COUNT_WIDTH(2)) dut_small (
        .clock(clock), .reset(reset), .bit_en(bit_en), .serial_in(serial_in),
        .data_out(data_out2), .data_valid(data_valid2), .parity_err(parity_err2),
        .frame_err(frame_err2), .busy(busy2), .error_count(error_count2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one bit; gap>1 spends gap-1 unstrobed cycles wiggling the line first.
    task automatic sendBit(input logic b, input int gap);
        for (int k = 0; k < gap - 1; k++) begin
            bit_en    = 1'b0;
            serial_in = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
        end
        bit_en    = 1'b1;
        serial_in = b;
        @(posedge clock); #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop,
                                 input int gap);
        exp_t e;
        e.data = data;
        e.perr = (^data) ^ par;
        e.ferr = ~stop;
        if ((e.perr | e.ferr) && model_cnt8 != 8'hFF) model_cnt8 = model_cnt8 + 8'd1;
        if ((e.perr | e.ferr) && model_cnt2 != 2'b11) model_cnt2 = model_cnt2 + 2'd1;
        e.cnt8 = model_cnt8;
        e.cnt2 = model_cnt2;
        sb.push_back(e);
        sendBit(START_LEVEL, gap);
        for (int i = 0; i < 8; i++) sendBit(data[i], gap);
        sendBit(par, gap);
        sendBit(stop, gap);
    endtask

    // One idle cycle after a frame: pulse must be gone and the frame consumed.
    task automatic idleCheck(input string tag);
        bit_en    = 1'b1;
        serial_in = IDLE_LEVEL;
        @(posedge clock); #1;
        checkOutput({tag, "_pulse_width"}, data_valid, 1'b0);
        checkOutput({tag, "_delivered"}, sb.size(), 0);
    endtask

    // Scoreboard consumer.
    always @(negedge clock) begin
        if (reset === 1'b1 && data_valid === 1'b1) begin
            checkOutput("valid_one_cycle", prev_valid, 1'b0);
            checkOutput("valid_small", data_valid2, 1'b1);
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("data_out", data_out, e.data);
                checkOutput("parity_err", parity_err, e.perr);
                checkOutput("frame_err", frame_err, e.ferr);
                checkOutput("error_count", error_count, e.cnt8);
                checkOutput("error_count_small", error_count2, e.cnt2);
                checkOutput("busy_after_stop", busy, 1'b0);
            end
        end
        prev_valid = data_valid;
    end

    initial begin
        reset     = 1'b0;
        bit_en    = 1'b1;
        serial_in = IDLE_LEVEL;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_data_out", data_out, 8'h00);
        checkOutput("rst_valid", data_valid, 1'b0);
        checkOutput("rst_perr", parity_err, 1'b0);
        checkOutput("rst_ferr", frame_err, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_count", error_count, 8'h00);
        reset = 1'b1;
        @(posedge clock); #1;

        applyStimulus(8'hA5, 1'b0, 1'b1, 1);
        idleCheck("clean_a5");
        applyStimulus(8'hA5, 1'b1, 1'b1, 1);
        idleCheck("perr_a5");
        applyStimulus(8'h01, 1'b1, 1'b1, 1);
        idleCheck("ok_01");
        applyStimulus(8'h3C, 1'b0, 1'b0, 1);
        applyStimulus(8'hFF, 1'b0, 1'b1, 1);
        idleCheck("b2b_ff");
        applyStimulus(8'h5A, 1'b0, 1'b1, 4);
        idleCheck("strobed_5a");

        sendBit(START_LEVEL, 1);
        for (int i = 0; i < 4; i++) sendBit(1'(i & 1), 1);
        checkOutput("busy_mid_frame", busy, 1'b1);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        serial_in = IDLE_LEVEL;
        model_cnt8 = '0;
        model_cnt2 = '0;
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_valid", data_valid, 1'b0);
        checkOutput("mid_rst_data", data_out, 8'h00);
        checkOutput("mid_rst_count", error_count, 8'h00);
        checkOutput("mid_rst_count_small", error_count2, 2'b00);
        @(posedge clock); #1;
        applyStimulus(8'h81, 1'b0, 1'b1, 1);
        idleCheck("after_rst_81");

        for (int n = 0; n < 5; n++) begin
            applyStimulus(8'h00, 1'b1, 1'b1, 1);
            idleCheck("sat_frame");
        end
        checkOutput("sat_final_small", error_count2, 2'b11);
        checkOutput("sat_final", error_count, 8'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
